// File: rtl/tx_power_ramp.sv
// ============================================================================
// Module      : tx_power_ramp
// Description : TX burst level control. Ramps a ufix_12_10 gain 0 -> target
//               -> 0 around each burst and applies it to sfix_12_9 I/Q.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_power_ramp #(
    parameter logic [11:0] RAMP_STEP = 12'h008
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        tx_en,
    input  logic [11:0] target_gain,
    input  logic [11:0] data_in_i,
    input  logic [11:0] data_in_q,
    output logic [11:0] data_out_i,
    output logic [11:0] data_out_q,
    output logic [11:0] ramp_gain,
    output logic [1:0]  state,
    output logic        tx_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic [11:0] gain;
    logic [11:0] gain_nxt;
    logic [11:0] tgt;
    logic [11:0] tgt_nxt;
    logic [12:0] up_sum;

    // Multiply by gain, floor-shift back to sfix_12_9, then saturate.
    function automatic logic [11:0] gain_sat(input logic [11:0] din, input logic [11:0] g);
        logic signed [24:0] p;
        logic signed [24:0] r;
        logic [11:0]        res;
        p = $signed({{13{din[11]}}, din}) * $signed({13'd0, g});
        r = p >>> 10;
        if (r > 25'sd2047)
            res = 12'h7FF;
        else if (r < -25'sd2048)
            res = 12'h800;
        else
            res = r[11:0];
        return res;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state  <= IDLE;
            gain       <= 12'd0;
            tgt        <= 12'd0;
            data_out_i <= 12'd0;
            data_out_q <= 12'd0;
        end else if (ce) begin
            cur_state  <= nxt_state;
            gain       <= gain_nxt;
            tgt        <= tgt_nxt;
            data_out_i <= gain_sat(data_in_i, gain);
            data_out_q <= gain_sat(data_in_q, gain);
        end
    end

    always_comb begin
        nxt_state = cur_state;
        gain_nxt  = gain;
        tgt_nxt   = tgt;
        up_sum    = {1'b0, gain} + {1'b0, RAMP_STEP};
        case (cur_state)
            IDLE: begin
                gain_nxt = 12'd0;
                if (tx_en) begin
                    tgt_nxt   = target_gain;
                    nxt_state = RAMP_UP;
                end
            end
            RAMP_UP: begin
                // An abort freezes the gain for one edge before it starts falling.
                if (!tx_en) begin
                    nxt_state = RAMP_DOWN;
                end else if (up_sum >= {1'b0, tgt}) begin
                    gain_nxt  = tgt;
                    nxt_state = HOLD;
                end else begin
                    gain_nxt = up_sum[11:0];
                end
            end
            HOLD: begin
                gain_nxt = tgt;
                if (!tx_en)
                    nxt_state = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (gain <= RAMP_STEP) begin
                    gain_nxt  = 12'd0;
                    nxt_state = IDLE;
                end else begin
                    gain_nxt = gain - RAMP_STEP;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign ramp_gain = gain;
    assign state     = cur_state;
    assign tx_busy   = (cur_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tx_power_ramp.sv
// ============================================================================
// Module      : tb_tx_power_ramp
// Description : Directed vector bench for tx_power_ramp (RAMP_STEP = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_power_ramp;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        tx_en;
    logic [11:0] target_gain;
    logic [11:0] data_in_i;
    logic [11:0] data_in_q;
    logic [11:0] data_out_i;
    logic [11:0] data_out_q;
    logic [11:0] ramp_gain;
    logic [1:0]  state;
    logic        tx_busy;

    int n_vec;
    int n_err;

    tx_power_ramp #(.RAMP_STEP(12'h008)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .tx_en       (tx_en),
        .target_gain (target_gain),
        .data_in_i   (data_in_i),
        .data_in_q   (data_in_q),
        .data_out_i  (data_out_i),
        .data_out_q  (data_out_q),
        .ramp_gain   (ramp_gain),
        .state       (state),
        .tx_busy     (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] tgt;
        logic [11:0] di;
        logic [11:0] dq;
        logic [11:0] ei;
        logic [11:0] eq;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output int n);
        n = 0;
        while (state !== s && n < budget) begin
            step();
            n++;
        end
        if (state !== s) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_state: got state %0d expected %0d after %0d edges", state, s, n);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        ce          = 1'b1;
        tx_en       = 1'b0;
        target_gain = 12'd0;
        data_in_i   = 12'd0;
        data_in_q   = 12'd0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;

        vt[0] = '{12'h400, 12'h200, 12'hE00, 12'h200, 12'hE00};
        vt[1] = '{12'hFFF, 12'h7FF, 12'h800, 12'h7FF, 12'h800};
        vt[2] = '{12'h200, 12'hFFF, 12'h001, 12'hFFF, 12'h000};
        vt[3] = '{12'h200, 12'h400, 12'hC00, 12'h200, 12'hE00};
        vt[4] = '{12'h600, 12'h7FF, 12'h100, 12'h7FF, 12'h180};
        vt[5] = '{12'h000, 12'h7FF, 12'h800, 12'h000, 12'h000};
        vt[6] = '{12'h300, 12'h003, 12'hFFD, 12'h002, 12'hFFD};

        // Reset state
        reset_n = 1'b0;
        ce = 1'b1; tx_en = 1'b0; target_gain = 12'd0;
        data_in_i = 12'h123; data_in_q = 12'h456;
        #12;
        check("rst_state", state, 0);
        check("rst_gain", ramp_gain, 0);
        check("rst_out_i", data_out_i, 0);
        check("rst_out_q", data_out_q, 0);
        check("rst_busy", tx_busy, 0);

        // Datapath vectors applied in HOLD
        for (int k = 0; k < 7; k++) begin
            do_reset();
            tx_en = 1'b1;
            target_gain = vt[k].tgt;
            wait_state(2'd2, 700, n);
            check($sformatf("v%0d_gain", k), ramp_gain, vt[k].tgt);
            data_in_i = vt[k].di;
            data_in_q = vt[k].dq;
            step();
            check($sformatf("v%0d_out_i", k), data_out_i, vt[k].ei);
            check($sformatf("v%0d_out_q", k), data_out_q, vt[k].eq);
        end

        // Basic burst timing
        do_reset();
        tx_en = 1'b1; target_gain = 12'h400;
        data_in_i = 12'h200; data_in_q = 12'hE00;
        step();
        check("burst_first_state", state, 1);
        check("burst_first_gain", ramp_gain, 0);
        target_gain = 12'h7FF;
        wait_state(2'd2, 200, n);
        check("burst_up_edges", n, 128);
        check("burst_hold_gain", ramp_gain, 12'h400);
        step();
        check("burst_out_i", data_out_i, 12'h200);
        check("burst_out_q", data_out_q, 12'hE00);
        tx_en = 1'b0;
        step();
        check("burst_down_state", state, 3);
        check("burst_down_gain", ramp_gain, 12'h400);
        wait_state(2'd0, 200, n);
        check("burst_down_edges", n, 128);
        check("burst_end_gain", ramp_gain, 0);
        check("burst_end_busy", tx_busy, 0);

        // Non-multiple target
        do_reset();
        tx_en = 1'b1; target_gain = 12'h00D;
        step();
        step();
        check("nm_gain1", ramp_gain, 12'h008);
        check("nm_state1", state, 1);
        step();
        check("nm_gain2", ramp_gain, 12'h00D);
        check("nm_state2", state, 2);
        tx_en = 1'b0;
        step();
        check("nm_dn_gain0", ramp_gain, 12'h00D);
        step();
        check("nm_dn_gain1", ramp_gain, 12'h005);
        check("nm_dn_state1", state, 3);
        step();
        check("nm_dn_gain2", ramp_gain, 12'h000);
        check("nm_dn_state2", state, 0);

        // Abort mid-ramp, re-request while falling
        do_reset();
        tx_en = 1'b1; target_gain = 12'h400;
        step();
        for (int k = 0; k < 32; k++) step();
        check("ab_gain_pre", ramp_gain, 12'h100);
        tx_en = 1'b0;
        step();
        check("ab_state", state, 3);
        check("ab_gain0", ramp_gain, 12'h100);
        tx_en = 1'b1; target_gain = 12'h010;
        step();
        check("ab_gain1", ramp_gain, 12'h0F8);
        step();
        check("ab_gain2", ramp_gain, 12'h0F0);
        check("ab_state2", state, 3);
        wait_state(2'd0, 100, n);
        check("ab_down_edges", n, 30);
        step();
        check("ab_restart_state", state, 1);
        check("ab_restart_gain", ramp_gain, 0);
        step();
        step();
        check("ab_new_tgt_state", state, 2);
        check("ab_new_tgt_gain", ramp_gain, 12'h010);

        // Clock-enable gating during RAMP_UP
        do_reset();
        tx_en = 1'b1; target_gain = 12'h400;
        data_in_i = 12'h200; data_in_q = 12'hE00;
        step();
        step();
        check("ce_gain_a", ramp_gain, 12'h008);
        step();
        check("ce_gain_b", ramp_gain, 12'h010);
        check("ce_out_b", data_out_i, 12'h004);
        ce = 1'b0;
        data_in_i = 12'h7FF;
        step();
        step();
        check("ce_gain_frozen", ramp_gain, 12'h010);
        check("ce_out_frozen", data_out_i, 12'h004);
        check("ce_state_frozen", state, 1);
        ce = 1'b1;
        step();
        check("ce_gain_c", ramp_gain, 12'h018);
        check("ce_out_c", data_out_i, 12'h01F);

        // Asynchronous reset during HOLD
        do_reset();
        tx_en = 1'b1; target_gain = 12'h010;
        data_in_i = 12'h400; data_in_q = 12'h400;
        wait_state(2'd2, 20, n);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_state", state, 0);
        check("ar_gain", ramp_gain, 0);
        check("ar_out_i", data_out_i, 0);
        check("ar_out_q", data_out_q, 0);
        check("ar_busy", tx_busy, 0);
        #1;
        reset_n = 1'b1;
        step();
        check("ar_restart_state", state, 1);
        check("ar_restart_gain", ramp_gain, 0);
        step();
        check("ar_ramp_gain", ramp_gain, 12'h008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
